rs_enc_core: RTL

- Systematic Reed-Solomon encoder, RS(N_NUM, N_NUM-R_NUM) over GF(2^SYM_BW). It is the transmit-side counterpart of the rs_dec chain.
- Accepts K = N_NUM-R_NUM message symbols through a valid/ready handshake, passes them straight through, then appends R_NUM parity symbols from an LFSR division by g(x).
- The output stream (symbol counter 1..N plus symbol) is in exactly the format the decoder consumes as symb_cnt/symb_with_err.

---
 rtl/rs_pkg.sv | 59 +++++
 rtl/gf_const_mul.sv | 30 +++
 rtl/rs_enc_core.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared Reed-Solomon definitions for the encoder and decoder chains:
// field defaults, encoder state encoding and elaboration-time GF helpers.
package rs_pkg;

    localparam int          SYM_BW_DEF    = 8;
    localparam int          N_NUM_DEF     = 255;
    localparam int          R_NUM_DEF     = 16;
    localparam int unsigned PRIM_POLY_DEF = 32'h11D;
    localparam int          COEF_MAX      = 64;

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_MSG  = 2'd1,
        ENC_PAR  = 2'd2
    } enc_state_e;

    // Generator coefficients g[0..R-1]; the monic x^R term is implied.
    typedef logic [COEF_MAX-1:0][15:0] coef_arr_t;

    function automatic int unsigned gf_mul(input int unsigned a, input int unsigned b,
                                           input int sym_bw, input int unsigned poly);
        int unsigned acc;
        int unsigned aa;
        int unsigned bb;
        acc = 0;
        aa  = a;
        bb  = b;
        for (int i = 0; i < sym_bw; i++) begin
            if ((bb & 32'd1) != 0) acc = acc ^ aa;
            bb = bb >> 1;
            aa = aa << 1;
            if (((aa >> sym_bw) & 32'd1) != 0) aa = aa ^ poly;
        end
        return acc;
    endfunction

    function automatic coef_arr_t gen_poly_coef(input int r_num, input int fcr,
                                                input int sym_bw, input int unsigned poly);
        logic [COEF_MAX:0][15:0] g;
        int unsigned root;
        coef_arr_t   res;
        g    = '0;
        g[0] = 16'd1;
        root = 1;
        for (int k = 0; k < fcr; k++) root = gf_mul(root, 2, sym_bw, poly);
        // Multiply the running product by (x + alpha^(fcr+i)), highest term first.
        for (int i = 0; i < r_num; i++) begin
            for (int j = i + 1; j > 0; j--) begin
                g[j] = g[j-1] ^ 16'(gf_mul(32'(g[j]), root, sym_bw, poly));
            end
            g[0] = 16'(gf_mul(32'(g[0]), root, sym_bw, poly));
            root = gf_mul(root, 2, sym_bw, poly);
        end
        res = '0;
        for (int k = 0; k < r_num; k++) res[k] = g[k];
        return res;
    endfunction

endpackage

// File: rtl/gf_const_mul.sv
// GF(2^m) multiply by an elaboration-time constant: each input bit selects
// a precomputed column COEF*alpha^bit, and the selected columns are XORed.
module gf_const_mul
    import rs_pkg::*;
#(
    parameter int          SYM_BW    = SYM_BW_DEF,
    parameter int unsigned PRIM_POLY = PRIM_POLY_DEF,
    parameter int unsigned COEF      = 1
) (
    input  logic [SYM_BW-1:0] din,
    output logic [SYM_BW-1:0] dout
);

    logic [SYM_BW-1:0] term [SYM_BW];

    genvar gi;
    generate
        for (gi = 0; gi < SYM_BW; gi++) begin : g_col
            localparam logic [SYM_BW-1:0] COL =
                SYM_BW'(gf_mul(COEF, 32'(1) << gi, SYM_BW, PRIM_POLY));
            assign term[gi] = din[gi] ? COL : '0;
        end
    endgenerate

    always_comb begin
        dout = '0;
        for (int i = 0; i < SYM_BW; i++) dout = dout ^ term[i];
    end

endmodule

// File: rtl/rs_enc_core.sv
// Systematic RS encoder: message symbols pass through with latency 1, then
// R_NUM parity symbols are shifted out of the g(x) division LFSR.
module rs_enc_core
    import rs_pkg::*;
#(
    parameter int          SYM_BW    = SYM_BW_DEF,
    parameter int          N_NUM     = N_NUM_DEF,
    parameter int          R_NUM     = R_NUM_DEF,
    parameter int unsigned PRIM_POLY = PRIM_POLY_DEF,
    parameter int          FCR       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sop,
    input  logic [SYM_BW-1:0] in_data,
    output logic              out_valid,
    output logic [SYM_BW-1:0] out_cnt,
    output logic [SYM_BW-1:0] out_data,
    output logic              out_is_par,
    output logic              sop_err
);

    localparam int K_NUM = N_NUM - R_NUM;
    localparam int PC_W  = $clog2(R_NUM + 1);

    localparam logic [1:0] ST_IDLE = ENC_IDLE;
    localparam logic [1:0] ST_MSG  = ENC_MSG;
    localparam logic [1:0] ST_PAR  = ENC_PAR;

    localparam coef_arr_t         G_COEF = gen_poly_coef(R_NUM, FCR, SYM_BW, PRIM_POLY);
    localparam logic [SYM_BW-1:0] K_SYM  = SYM_BW'(K_NUM);

    logic [1:0]        state_q,      state_d;
    logic [SYM_BW-1:0] msg_cnt_q,    msg_cnt_d;
    logic [PC_W-1:0]   par_cnt_q,    par_cnt_d;
    logic [SYM_BW-1:0] par_q [R_NUM];
    logic [SYM_BW-1:0] par_d [R_NUM];
    logic              out_valid_q,  out_valid_d;
    logic [SYM_BW-1:0] out_cnt_q,    out_cnt_d;
    logic [SYM_BW-1:0] out_data_q,   out_data_d;
    logic              out_is_par_q, out_is_par_d;
    logic              sop_err_q,    sop_err_d;

    logic              accept;
    logic [SYM_BW-1:0] pos;
    logic [SYM_BW-1:0] fb;
    logic [SYM_BW-1:0] par_src   [R_NUM];
    logic [SYM_BW-1:0] fb_mul    [R_NUM];
    logic [SYM_BW-1:0] par_lfsr  [R_NUM];
    logic [SYM_BW-1:0] par_shift [R_NUM];

    assign in_ready = (state_q != ST_PAR);
    assign accept   = in_valid & in_ready;
    assign fb       = in_data ^ par_src[R_NUM-1];

    // A block-start symbol divides from a clean remainder, whatever is left in par_q.
    genvar gi;
    generate
        for (gi = 0; gi < R_NUM; gi++) begin : g_tap
            assign par_src[gi] = in_sop ? '0 : par_q[gi];

            gf_const_mul #(
                .SYM_BW    (SYM_BW),
                .PRIM_POLY (PRIM_POLY),
                .COEF      (32'(G_COEF[gi]))
            ) u_mul (
                .din  (fb),
                .dout (fb_mul[gi])
            );

            if (gi == 0) begin : g_low
                assign par_lfsr[gi]  = fb_mul[gi];
                assign par_shift[gi] = '0;
            end else begin : g_high
                assign par_lfsr[gi]  = par_src[gi-1] ^ fb_mul[gi];
                assign par_shift[gi] = par_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        msg_cnt_d    = msg_cnt_q;
        par_cnt_d    = par_cnt_q;
        par_d        = par_q;
        out_valid_d  = 1'b0;
        out_cnt_d    = '0;
        out_data_d   = '0;
        out_is_par_d = 1'b0;
        sop_err_d    = 1'b0;
        pos          = '0;

        case (state_q)
            ST_IDLE, ST_MSG: begin
                if (accept) begin
                    if (in_sop || state_q == ST_MSG) begin
                        pos         = in_sop ? SYM_BW'(1) : msg_cnt_q + SYM_BW'(1);
                        sop_err_d   = in_sop && (state_q == ST_MSG);
                        par_d       = par_lfsr;
                        out_valid_d = 1'b1;
                        out_cnt_d   = pos;
                        out_data_d  = in_data;
                        if (pos == K_SYM) begin
                            state_d   = ST_PAR;
                            msg_cnt_d = '0;
                            par_cnt_d = '0;
                        end else begin
                            state_d   = ST_MSG;
                            msg_cnt_d = pos;
                        end
                    end else begin
                        sop_err_d = 1'b1;
                    end
                end
            end
            ST_PAR: begin
                out_valid_d  = 1'b1;
                out_cnt_d    = K_SYM + SYM_BW'(par_cnt_q) + SYM_BW'(1);
                out_data_d   = par_q[R_NUM-1];
                out_is_par_d = 1'b1;
                par_d        = par_shift;
                if (par_cnt_q == PC_W'(R_NUM - 1)) begin
                    state_d   = ST_IDLE;
                    par_cnt_d = '0;
                end else begin
                    par_cnt_d = par_cnt_q + PC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            msg_cnt_q    <= '0;
            par_cnt_q    <= '0;
            for (int i = 0; i < R_NUM; i++) par_q[i] <= '0;
            out_valid_q  <= 1'b0;
            out_cnt_q    <= '0;
            out_data_q   <= '0;
            out_is_par_q <= 1'b0;
            sop_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            msg_cnt_q    <= msg_cnt_d;
            par_cnt_q    <= par_cnt_d;
            par_q        <= par_d;
            out_valid_q  <= out_valid_d;
            out_cnt_q    <= out_cnt_d;
            out_data_q   <= out_data_d;
            out_is_par_q <= out_is_par_d;
            sop_err_q    <= sop_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_cnt    = out_cnt_q;
    assign out_data   = out_data_q;
    assign out_is_par = out_is_par_q;
    assign sop_err    = sop_err_q;

endmodule
